// File: rtl/scroll_strip_gen_if.sv
// Bus bundle between a scrolling-strip generator, its pixel ROM and the layer mixer.
// The master side (the generator) drives the ROM address and the pixel outputs;
// the slave side (ROM + mixer) returns ROM data and consumes the pixel.
interface scroll_strip_gen_if #(
    parameter int ADDR_W = 17
);
    logic [ADDR_W-1:0] rom_addr;
    logic [11:0]       rom_data;
    logic [3:0]        vgaRed;
    logic [3:0]        vgaGreen;
    logic [3:0]        vgaBlue;
    logic              hit;

    modport master (
        output rom_addr,
        input  rom_data,
        output vgaRed,
        output vgaGreen,
        output vgaBlue,
        output hit
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  vgaRed,
        input  vgaGreen,
        input  vgaBlue,
        input  hit
    );
endinterface

// File: rtl/scroll_strip_gen.sv
// Scrolling-strip pixel generator for one horizontally wrapping layer.
// A run-time scroll offset is advanced on game ticks, latched once per frame
// so the strip never tears, and used to address an external synchronous ROM.
// Pixels come out ROM_LAT+2 cycles after the VGA counters that produced them,
// with an optional colour key that turns matching pixels transparent.
module scroll_strip_gen #(
    parameter int          WIDTH     = 1187,
    parameter int          HEIGHT    = 14,
    parameter int          Y0        = 144,
    parameter int          H_ACTIVE  = 640,
    parameter int          ADDR_W    = 17,
    parameter int          OFS_W     = 11,
    parameter int          STEP_W    = 4,
    parameter int          ROM_LAT   = 1,
    parameter logic [11:0] BG_COLOR  = 12'hFFF,
    parameter bit          KEY_EN    = 1'b1,
    parameter logic [11:0] KEY_COLOR = 12'hFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              game_tick,
    input  logic              scroll_en,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [9:0]        h_cnt,
    input  logic [9:0]        v_cnt,
    scroll_strip_gen_if.master bus,
    output logic [OFS_W-1:0]  offset
);

    // One extra bit so offset+step and h_cnt+offset never overflow before the wrap.
    localparam int               SUM_W   = OFS_W + 1;
    localparam logic [SUM_W-1:0] WIDTH_S = SUM_W'(WIDTH);
    localparam logic [10:0]      Y_LO    = 11'(Y0);
    localparam logic [10:0]      Y_HI    = 11'(Y0 + HEIGHT);
    localparam logic [10:0]      H_LIM   = 11'(H_ACTIVE);

    // Parameter sanity: the wrap arithmetic relies on every one of these.
    if (ROM_LAT < 1) begin : g_bad_rom_lat
        $error("scroll_strip_gen: ROM_LAT must be at least 1");
    end
    if (WIDTH * HEIGHT > (1 << ADDR_W)) begin : g_bad_addr_w
        $error("scroll_strip_gen: WIDTH*HEIGHT does not fit in ADDR_W bits");
    end
    if (WIDTH > (1 << OFS_W)) begin : g_bad_ofs_w
        $error("scroll_strip_gen: WIDTH does not fit in OFS_W bits");
    end
    if ((1 << STEP_W) - 1 >= WIDTH) begin : g_bad_step_w
        $error("scroll_strip_gen: largest step must be smaller than WIDTH");
    end
    if (H_ACTIVE > WIDTH) begin : g_bad_h_active
        $error("scroll_strip_gen: H_ACTIVE must not exceed WIDTH");
    end

    logic [OFS_W-1:0]   ofs_q;
    logic [OFS_W-1:0]   disp_ofs_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic               band_s1_q;
    logic [ROM_LAT-1:0] band_dly_q;
    logic [11:0]        color_q;
    logic               hit_q;

    logic [SUM_W-1:0]   ofs_ext;
    logic [SUM_W-1:0]   step_ext;
    logic [SUM_W-1:0]   fwd_sum;
    logic [SUM_W-1:0]   fwd_wrap;
    logic [SUM_W-1:0]   bwd_wrap;
    logic [OFS_W-1:0]   ofs_next;
    logic               advance;
    logic               frame_start;

    logic               in_band;
    logic [9:0]         row;
    logic [ADDR_W-1:0]  row_base;
    logic [SUM_W-1:0]   col_sum;
    logic [SUM_W-1:0]   col;
    logic [ADDR_W-1:0]  addr_next;

    // Next scroll offset: modular add for leftward motion, modular subtract for rightward.
    always_comb begin
        ofs_ext  = {1'b0, ofs_q};
        step_ext = SUM_W'(step);
        fwd_sum  = ofs_ext + step_ext;
        fwd_wrap = (fwd_sum >= WIDTH_S) ? (fwd_sum - WIDTH_S) : fwd_sum;
        bwd_wrap = (ofs_ext >= step_ext) ? (ofs_ext - step_ext)
                                         : (ofs_ext + WIDTH_S - step_ext);
        ofs_next = dir ? OFS_W'(bwd_wrap) : OFS_W'(fwd_wrap);
    end

    assign advance     = game_tick & scroll_en;
    assign frame_start = (h_cnt == 10'd0) && (v_cnt == 10'd0);

    // Live scroll register, moved only by an enabled game tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ofs_q <= '0;
        end else if (advance) begin
            ofs_q <= ofs_next;
        end
    end

    // Frame latch: rendering sees one offset per frame, taken before any same-cycle tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_ofs_q <= '0;
        end else if (frame_start) begin
            disp_ofs_q <= ofs_q;
        end
    end

    // Band detection and ROM address for the current beam position.
    always_comb begin
        in_band   = ({1'b0, v_cnt} >= Y_LO) && ({1'b0, v_cnt} < Y_HI) &&
                    ({1'b0, h_cnt} < H_LIM);
        row       = v_cnt - 10'(Y0);
        row_base  = ADDR_W'(row) * ADDR_W'(WIDTH);
        col_sum   = SUM_W'(h_cnt) + {1'b0, disp_ofs_q};
        col       = (col_sum >= WIDTH_S) ? (col_sum - WIDTH_S) : col_sum;
        addr_next = in_band ? (row_base + ADDR_W'(col)) : '0;
    end

    // Stage 1: register the ROM address and the matching band flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr_q <= '0;
            band_s1_q  <= 1'b0;
        end else begin
            rom_addr_q <= addr_next;
            band_s1_q  <= in_band;
        end
    end

    // Band flag travels alongside the ROM read so it lines up with rom_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            band_dly_q <= '0;
        end else begin
            band_dly_q[0] <= band_s1_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                band_dly_q[i] <= band_dly_q[i-1];
            end
        end
    end

    // Stage 2: pick background, keyed-transparent or opaque ROM pixel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            color_q <= BG_COLOR;
            hit_q   <= 1'b0;
        end else if (!band_dly_q[ROM_LAT-1]) begin
            color_q <= BG_COLOR;
            hit_q   <= 1'b0;
        end else if (KEY_EN && (bus.rom_data == KEY_COLOR)) begin
            color_q <= BG_COLOR;
            hit_q   <= 1'b0;
        end else begin
            color_q <= bus.rom_data;
            hit_q   <= 1'b1;
        end
    end

    assign bus.rom_addr = rom_addr_q;
    assign bus.vgaRed   = color_q[11:8];
    assign bus.vgaGreen = color_q[7:4];
    assign bus.vgaBlue  = color_q[3:0];
    assign bus.hit      = hit_q;
    assign offset       = ofs_q;

endmodule

// File: tb/tb_scroll_strip_gen.sv
// Directed testbench for scroll_strip_gen at default parameters.
// The bench supplies a 1-cycle synchronous ROM whose content is a fixed
// function of the address, so every expected pixel is known up front.
module tb_scroll_strip_gen;

    localparam int WIDTH = 1187;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        game_tick = 1'b0;
    logic        scroll_en = 1'b0;
    logic        dir       = 1'b0;
    logic [3:0]  step      = 4'd0;
    logic [9:0]  h_cnt     = 10'd700;
    logic [9:0]  v_cnt     = 10'd500;
    logic [10:0] offset;

    logic        override_en  = 1'b0;
    logic [11:0] override_val = 12'h000;

    int errors = 0;
    int checks = 0;
    int model_ofs = 0;

    scroll_strip_gen_if #(.ADDR_W(17)) bus ();

    scroll_strip_gen dut (
        .clk       (clk),
        .rst       (rst),
        .game_tick (game_tick),
        .scroll_en (scroll_en),
        .dir       (dir),
        .step      (step),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .bus       (bus),
        .offset    (offset)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    // ROM content: pixel = low 12 address bits XOR 3C5
    function automatic logic [11:0] pix(input logic [16:0] a);
        return a[11:0] ^ 12'h3C5;
    endfunction

    // Synchronous ROM, one cycle of read latency, with a forced-value override
    always @(posedge clk) begin
        bus.rom_data <= override_en ? override_val : pix(bus.rom_addr);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pos(input int h, input int v);
        h_cnt = 10'(h);
        v_cnt = 10'(v);
    endtask

    task automatic do_tick(input logic en, input logic d, input int s);
        scroll_en = en;
        dir       = d;
        step      = 4'(s);
        game_tick = 1'b1;
        tick();
        game_tick = 1'b0;
        if (en) begin
            if (d == 1'b0) begin
                model_ofs = model_ofs + s;
                if (model_ofs >= WIDTH) model_ofs = model_ofs - WIDTH;
            end else begin
                model_ofs = model_ofs - s;
                if (model_ofs < 0) model_ofs = model_ofs + WIDTH;
            end
        end
    endtask

    task automatic goto_ofs(input int target);
        set_pos(700, 500);
        for (int k = 0; k < 200 && model_ofs != target; k++) begin
            int fwd;
            int bwd;
            fwd = (target - model_ofs + WIDTH) % WIDTH;
            bwd = WIDTH - fwd;
            if (fwd <= bwd) do_tick(1'b1, 1'b0, (fwd > 15) ? 15 : fwd);
            else            do_tick(1'b1, 1'b1, (bwd > 15) ? 15 : bwd);
        end
    endtask

    task automatic test_reset();
        #23;
        checks++; if (offset !== 11'd0) begin errors++; $display("[TB] FAIL reset_offset: got %0d expected 0", offset); end
        checks++; if (bus.rom_addr !== 17'd0) begin errors++; $display("[TB] FAIL reset_addr: got %0d expected 0", bus.rom_addr); end
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'hFFF) begin errors++; $display("[TB] FAIL reset_color: got %h expected fff", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}); end
        checks++; if (bus.hit !== 1'b0) begin errors++; $display("[TB] FAIL reset_hit: got %b expected 0", bus.hit); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_scan();
        logic [16:0] a_list [4];
        int          h_list [4];
        int          v_list [4];
        a_list = '{17'd2379, 17'd0, 17'd0, 17'd15431};
        h_list = '{5, 5, 640, 0};
        v_list = '{146, 143, 146, 157};
        a_list[2] = 17'd0;
        for (int i = 0; i < 4; i++) begin
            logic [11:0] ec;
            logic        eh;
            eh = (i == 0 || i == 3);
            ec = eh ? pix(a_list[i]) : 12'hFFF;
            set_pos(h_list[i], v_list[i]);
            tick();
            checks++; if (bus.rom_addr !== a_list[i]) begin errors++; $display("[TB] FAIL scan_addr[%0d]: got %0d expected %0d", i, bus.rom_addr, a_list[i]); end
            tick();
            tick();
            checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== ec) begin errors++; $display("[TB] FAIL scan_color[%0d]: got %h expected %h", i, {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, ec); end
            checks++; if (bus.hit !== eh) begin errors++; $display("[TB] FAIL scan_hit[%0d]: got %b expected %b", i, bus.hit, eh); end
        end
        // v = Y0+HEIGHT is just below the band
        set_pos(5, 158);
        tick();
        tick();
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL scan_below_band: got %h/%b expected fff/0", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            logic [16:0] ea;
            logic [11:0] ec;
            set_pos(100 + i, 145);
            tick();
            ea = 17'(1187 + 100 + i);
            checks++; if (bus.rom_addr !== ea) begin errors++; $display("[TB] FAIL b2b_addr[%0d]: got %0d expected %0d", i, bus.rom_addr, ea); end
            if (i >= 2) begin
                ec = pix(17'(1187 + 100 + i - 2));
                checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== ec || bus.hit !== 1'b1) begin errors++; $display("[TB] FAIL b2b_color[%0d]: got %h/%b expected %h/1", i, {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit, ec); end
            end
        end
    endtask

    task automatic test_wrap();
        goto_ofs(1183);
        checks++; if (offset !== 11'd1183) begin errors++; $display("[TB] FAIL wrap_setup: got %0d expected 1183", offset); end
        do_tick(1'b1, 1'b0, 7);
        checks++; if (offset !== 11'd3) begin errors++; $display("[TB] FAIL wrap_fwd: got %0d expected 3", offset); end
        do_tick(1'b1, 1'b1, 5);
        checks++; if (offset !== 11'd1185) begin errors++; $display("[TB] FAIL wrap_bwd: got %0d expected 1185", offset); end
        do_tick(1'b1, 1'b0, 0);
        checks++; if (offset !== 11'd1185) begin errors++; $display("[TB] FAIL step_zero: got %0d expected 1185", offset); end
        // Controls changed without a tick must not move the offset
        scroll_en = 1'b1;
        dir       = 1'b1;
        step      = 4'd9;
        tick();
        tick();
        checks++; if (offset !== 11'd1185) begin errors++; $display("[TB] FAIL no_tick_hold: got %0d expected 1185", offset); end
    endtask

    task automatic test_frame_latch();
        goto_ofs(1000);
        checks++; if (offset !== 11'd1000) begin errors++; $display("[TB] FAIL latch_setup: got %0d expected 1000", offset); end
        set_pos(0, 0);
        tick();
        set_pos(300, 150);
        tick();
        checks++; if (bus.rom_addr !== 17'd7235) begin errors++; $display("[TB] FAIL latch_col113: got %0d expected 7235", bus.rom_addr); end
        do_tick(1'b1, 1'b0, 10);
        checks++; if (offset !== 11'd1010) begin errors++; $display("[TB] FAIL latch_midframe_ofs: got %0d expected 1010", offset); end
        set_pos(300, 151);
        tick();
        checks++; if (bus.rom_addr !== 17'd8422) begin errors++; $display("[TB] FAIL latch_midframe_addr: got %0d expected 8422", bus.rom_addr); end
        set_pos(0, 0);
        tick();
        set_pos(300, 150);
        tick();
        checks++; if (bus.rom_addr !== 17'd7245) begin errors++; $display("[TB] FAIL latch_next_frame: got %0d expected 7245", bus.rom_addr); end
        tick();
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue} !== 12'hF88) begin errors++; $display("[TB] FAIL latch_color: got %h expected f88", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}); end
    endtask

    task automatic test_coincident();
        goto_ofs(20);
        checks++; if (offset !== 11'd20) begin errors++; $display("[TB] FAIL coin_setup: got %0d expected 20", offset); end
        set_pos(0, 0);
        do_tick(1'b1, 1'b0, 4);
        checks++; if (offset !== 11'd24) begin errors++; $display("[TB] FAIL coin_ofs: got %0d expected 24", offset); end
        set_pos(10, 144);
        tick();
        checks++; if (bus.rom_addr !== 17'd30) begin errors++; $display("[TB] FAIL coin_this_frame: got %0d expected 30", bus.rom_addr); end
        set_pos(0, 0);
        tick();
        set_pos(10, 144);
        tick();
        checks++; if (bus.rom_addr !== 17'd34) begin errors++; $display("[TB] FAIL coin_next_frame: got %0d expected 34", bus.rom_addr); end
    endtask

    task automatic test_key_pause();
        set_pos(10, 144);
        override_en  = 1'b1;
        override_val = 12'hFFF;
        tick();
        tick();
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL key_transparent: got %h/%b expected fff/0", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        override_val = 12'h0A3;
        tick();
        tick();
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'h0A3, 1'b1}) begin errors++; $display("[TB] FAIL key_opaque: got %h/%b expected 0a3/1", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        override_en = 1'b0;
        set_pos(700, 500);
        do_tick(1'b0, 1'b0, 5);
        do_tick(1'b0, 1'b1, 5);
        checks++; if (offset !== 11'd24) begin errors++; $display("[TB] FAIL pause_hold: got %0d expected 24", offset); end
    endtask

    task automatic test_reset_midband();
        set_pos(5, 146);
        tick();
        tick();
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hAA6, 1'b1}) begin errors++; $display("[TB] FAIL prereset_pixel: got %h/%b expected aa6/1", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL async_reset_out: got %h/%b expected fff/0", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        checks++; if (offset !== 11'd0 || bus.rom_addr !== 17'd0) begin errors++; $display("[TB] FAIL async_reset_regs: got ofs %0d addr %0d expected 0 0", offset, bus.rom_addr); end
        #1;
        rst = 1'b1;
        model_ofs = 0;
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL refill_c1: got %h/%b expected fff/0", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hFFF, 1'b0}) begin errors++; $display("[TB] FAIL refill_c2: got %h/%b expected fff/0", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
        tick();
        checks++; if ({bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.hit} !== {12'hA8E, 1'b1}) begin errors++; $display("[TB] FAIL refill_c3: got %h/%b expected a8e/1", {bus.vgaRed, bus.vgaGreen, bus.vgaBlue}, bus.hit); end
    endtask

    // Run every scenario in order, then report
    initial begin
        $display("[TB] scroll_strip_gen directed test start");
        test_reset();
        test_scan();
        test_back_to_back();
        test_wrap();
        test_frame_latch();
        test_coincident();
        test_key_pause();
        test_reset_midband();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
